// File: rtl/fibonacci_checker.sv
// Receive-side Fibonacci stream checker with a Wishbone classic slave register file.
// Optional first-mismatch capture (FIRST_EXP/FIRST_OBS) is built when FIB_CHECK_FIRST_ERR_EN is defined.
module fibonacci_checker #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LOCK_RUN = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             locked,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED0 = 2'd1,
        SEED1 = 2'd2,
        CHECK = 2'd3
    } state_e;

    localparam logic [7:0]  RUN_MAX  = 8'(LOCK_RUN);
    localparam logic [31:0] CNT_MAX  = '1;
    localparam logic [2:0]  A_CTRL   = 3'd0;
    localparam logic [2:0]  A_STATUS = 3'd1;
    localparam logic [2:0]  A_MATCH  = 3'd2;
    localparam logic [2:0]  A_ERR    = 3'd3;
`ifdef FIB_CHECK_FIRST_ERR_EN
    localparam logic [2:0]  A_FEXP   = 3'd4;
    localparam logic [2:0]  A_FOBS   = 3'd5;
`endif

    logic [WIDTH-1:0] v_q;
    logic [WIDTH-1:0] p1_q, p1_d;
    logic [WIDTH-1:0] p2_q, p2_d;
    logic [WIDTH-1:0] exp_w;
    state_e           state_q, state_d;
    logic [31:0]      match_q, match_d;
    logic [31:0]      err_q, err_d;
    logic [7:0]       run_q, run_d;
    logic             err_flag_q, err_flag_d;
    logic             enable_q, enable_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [31:0]      rd_mux;
    logic             bus_req;
    logic             ctrl_wr;
    logic             clear;
    logic             unused_bus;

    assign unused_bus = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:2]};

    assign exp_w     = p1_q + p2_q;
    assign locked    = (state_q == CHECK) && (run_q == RUN_MAX);
    assign error     = err_flag_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;

`ifdef FIB_CHECK_FIRST_ERR_EN
    logic [WIDTH-1:0] fexp_q, fexp_d;
    logic [WIDTH-1:0] fobs_q, fobs_d;
    logic             fvld_q, fvld_d;
`endif

    // Bus decode; ack_q masks a held strobe so each access acks exactly once.
    always_comb begin
        bus_req  = wbs_stb_i & wbs_cyc_i & ~ack_q;
        ctrl_wr  = bus_req & wbs_we_i & wbs_sel_i[0] & (wbs_adr_i[4:2] == A_CTRL);
        enable_d = ctrl_wr ? wbs_dat_i[0] : enable_q;
        clear    = ctrl_wr & wbs_dat_i[1];
        ack_d    = bus_req;
    end

    always_comb begin
        rd_mux = '0;
        case (wbs_adr_i[4:2])
            A_CTRL:   rd_mux = {31'b0, enable_q};
            A_STATUS: rd_mux = {28'b0, err_flag_q, locked, state_q};
            A_MATCH:  rd_mux = match_q;
            A_ERR:    rd_mux = err_q;
`ifdef FIB_CHECK_FIRST_ERR_EN
            A_FEXP:   rd_mux = 32'(fexp_q);
            A_FOBS:   rd_mux = 32'(fobs_q);
`endif
            default:  rd_mux = '0;
        endcase
        rdat_d = (bus_req && !wbs_we_i) ? rd_mux : '0;
    end

    // Next-state: a clear overrides any compare in the same cycle.
    always_comb begin
        state_d    = state_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        match_d    = match_q;
        err_d      = err_q;
        run_d      = run_q;
        err_flag_d = err_flag_q;

        if (clear) begin
            state_d    = enable_d ? SEED0 : IDLE;
            match_d    = '0;
            err_d      = '0;
            run_d      = '0;
            err_flag_d = 1'b0;
        end else if (!enable_d) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SEED0;
                SEED0: begin
                    p2_d    = v_q;
                    state_d = SEED1;
                end
                SEED1: begin
                    p1_d    = v_q;
                    state_d = CHECK;
                end
                CHECK: begin
                    p2_d = p1_q;
                    p1_d = v_q;
                    if (v_q == exp_w) begin
                        match_d = (match_q == CNT_MAX) ? match_q : match_q + 32'd1;
                        run_d   = (run_q == RUN_MAX) ? run_q : run_q + 8'd1;
                    end else begin
                        err_d      = (err_q == CNT_MAX) ? err_q : err_q + 32'd1;
                        run_d      = '0;
                        err_flag_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != CHECK) begin
            run_d = '0;
        end
    end

`ifdef FIB_CHECK_FIRST_ERR_EN
    always_comb begin
        fexp_d = fexp_q;
        fobs_d = fobs_q;
        fvld_d = fvld_q;
        if (clear) begin
            fexp_d = '0;
            fobs_d = '0;
            fvld_d = 1'b0;
        end else if (enable_d && (state_q == CHECK) && (v_q != exp_w) && !fvld_q) begin
            fexp_d = exp_w;
            fobs_d = v_q;
            fvld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fexp_q <= '0;
            fobs_q <= '0;
            fvld_q <= 1'b0;
        end else begin
            fexp_q <= fexp_d;
            fobs_q <= fobs_d;
            fvld_q <= fvld_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q        <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            state_q    <= IDLE;
            match_q    <= '0;
            err_q      <= '0;
            run_q      <= '0;
            err_flag_q <= 1'b0;
            enable_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
        end else begin
            v_q        <= value;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            state_q    <= state_d;
            match_q    <= match_d;
            err_q      <= err_d;
            run_q      <= run_d;
            err_flag_q <= err_flag_d;
            enable_q   <= enable_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
        end
    end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed/randomized bench for fibonacci_checker: a 32-bit and an 8-bit instance share one
// Wishbone master and are checked against a sequence-level reference model of the stream.
module tb_fibonacci_checker;

    localparam int LOCK_RUN = 8;
    localparam int N        = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] value32;
    logic [7:0]  value8;
    logic        stb, wb_cyc, we;
    logic [3:0]  sel;
    logic [31:0] dati, adr;
    logic        ack32, ack8;
    logic [31:0] dat32, dat8;
    logic        locked32, locked8, error32, error8;

    always #5 clk = ~clk;

    fibonacci_checker #(.WIDTH(32), .LOCK_RUN(LOCK_RUN)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .value(value32),
        .wbs_stb_i(stb), .wbs_cyc_i(wb_cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dati), .wbs_adr_i(adr), .wbs_ack_o(ack32), .wbs_dat_o(dat32),
        .locked(locked32), .error(error32)
    );

    fibonacci_checker #(.WIDTH(8), .LOCK_RUN(LOCK_RUN)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .value(value8),
        .wbs_stb_i(stb), .wbs_cyc_i(wb_cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dati), .wbs_adr_i(adr), .wbs_ack_o(ack8), .wbs_dat_o(dat8),
        .locked(locked8), .error(error8)
    );

    // Stream terms driven in cycle n; s8 holds values already reduced mod 256.
    logic [31:0] s32 [N];
    logic [31:0] s8  [N];

    int cyc_n;
    int run_e;
    int off_d;
    bit have_run;
    bit en_on;
    int n_vec;
    int n_err;

    typedef struct packed {
        logic [31:0] mcnt;
        logic [31:0] ecnt;
        logic [7:0]  run;
        logic [31:0] fexp;
        logic [31:0] fobs;
        logic        fvld;
    } res_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Walks the observed stream from the seed pair: term j must equal the sum of the two terms before it.
    function automatic res_t model(input int p, input bit narrow);
        res_t        r;
        logic [31:0] mask, a, b, o, e;
        int          lj;
        r    = '0;
        mask = narrow ? 32'h0000_00FF : 32'hFFFF_FFFF;
        if (!have_run) return r;
        lj = en_on ? p - 2 : off_d - 3;
        for (int j = run_e + 1; j <= lj; j++) begin
            a = narrow ? s8[j-1] : s32[j-1];
            b = narrow ? s8[j-2] : s32[j-2];
            o = narrow ? s8[j]   : s32[j];
            e = (a + b) & mask;
            if (o == e) begin
                r.mcnt++;
                if (r.run < LOCK_RUN) r.run++;
            end else begin
                r.ecnt++;
                r.run = '0;
                if (!r.fvld) begin
                    r.fvld = 1'b1;
                    r.fexp = e;
                    r.fobs = o;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_state(input int p);
        if (!have_run || !en_on) return 2'd0;
        if (p - run_e <= 0) return 2'd1;
        if (p - run_e == 1) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [31:0] a, input int p, input bit narrow);
        res_t        r;
        logic        lk;
        logic [31:0] res;
        logic [2:0]  idx;
        r   = model(p, narrow);
        lk  = en_on && (r.run == LOCK_RUN);
        idx = a[4:2];
        res = '0;
        case (idx)
            3'd0: res = {31'b0, en_on};
            3'd1: res = {28'b0, (r.ecnt != 0), lk, exp_state(p)};
            3'd2: res = r.mcnt;
            3'd3: res = r.ecnt;
`ifdef FIB_CHECK_FIRST_ERR_EN
            3'd4: res = r.fexp;
            3'd5: res = r.fobs;
`endif
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic tick();
        res_t r32, r8;
        @(posedge clk);
        #1;
        cyc_n++;
        value32 = s32[cyc_n];
        value8  = s8[cyc_n][7:0];
        if (reset_n) begin
            r32 = model(cyc_n, 1'b0);
            r8  = model(cyc_n, 1'b1);
            check("locked32", {31'b0, locked32}, {31'b0, en_on && (r32.run == LOCK_RUN)});
            check("locked8",  {31'b0, locked8},  {31'b0, en_on && (r8.run == LOCK_RUN)});
            check("error32",  {31'b0, error32},  {31'b0, r32.ecnt != 0});
            check("error8",   {31'b0, error8},   {31'b0, r8.ecnt != 0});
        end
    endtask

    task automatic fill(input int from, input logic [31:0] a, input logic [31:0] b, input int n);
        for (int i = 0; i < n && from + i < N; i++) begin
            if (i == 0) begin
                s32[from] = a;
                s8[from]  = a & 32'hFF;
            end else if (i == 1) begin
                s32[from+1] = b;
                s8[from+1]  = b & 32'hFF;
            end else begin
                s32[from+i] = s32[from+i-1] + s32[from+i-2];
                s8[from+i]  = (s8[from+i-1] + s8[from+i-2]) & 32'hFF;
            end
        end
    endtask

    task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sl, output logic [31:0] r32, output logic [31:0] r8);
        int waits;
        int p;
        waits  = 0;
        p      = cyc_n;
        stb    = 1'b1;
        wb_cyc = 1'b1;
        we     = wr;
        adr    = a;
        dati   = d;
        sel    = sl;
        if (wr && sl[0] && a[4:2] == 3'd0) begin
            if (d[1]) begin
                have_run = d[0];
                en_on    = d[0];
                run_e    = p + 1;
            end else if (d[0] && !en_on) begin
                have_run = 1'b1;
                en_on    = 1'b1;
                run_e    = p + 1;
            end else if (!d[0] && en_on) begin
                en_on = 1'b0;
                off_d = p + 1;
            end
        end
        do begin
            tick();
            waits++;
        end while (!ack32 && waits < 5);
        check("ack_latency", waits, 1);
        check("ack8", {31'b0, ack8}, 32'd1);
        r32    = dat32;
        r8     = dat8;
        stb    = 1'b0;
        wb_cyc = 1'b0;
        we     = 1'b0;
        tick();
        check("ack_single", {31'b0, ack32}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          output logic [31:0] r32, output logic [31:0] r8);
        logic [31:0] e32, e8;
        e32 = exp_reg(a, cyc_n, 1'b0);
        e8  = exp_reg(a, cyc_n, 1'b1);
        bus(1'b0, a, '0, 4'hF, r32, r8);
        check({tag, "_w32"}, r32, e32);
        check({tag, "_w8"},  r8,  e8);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        logic [31:0] d32, d8;
        bus(1'b1, a, d, sl, d32, d8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r32, r8;
        logic [31:0] sa, sb;
        int          base;

        n_vec    = 0;
        n_err    = 0;
        cyc_n    = 0;
        have_run = 1'b0;
        en_on    = 1'b0;
        run_e    = 0;
        off_d    = 0;
        for (int i = 0; i < N; i++) begin
            s32[i] = $urandom;
            s8[i]  = $urandom & 32'hFF;
        end
        stb     = 1'b0;
        wb_cyc  = 1'b0;
        we      = 1'b0;
        sel     = 4'h0;
        adr     = '0;
        dati    = '0;
        value32 = s32[0];
        value8  = s8[0][7:0];
        reset_n = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ack",    {31'b0, ack32},    32'd0);
        check("rst_dat",    dat32,             32'd0);
        check("rst_locked", {31'b0, locked32}, 32'd0);
        check("rst_error",  {31'b0, error8},   32'd0);
        reset_n = 1'b1;
        tick();
        rd_chk("rst_ctrl",   32'h00, r32, r8);
        rd_chk("rst_status", 32'h04, r32, r8);

        // Clean stream 0,1,1,2,... (8-bit copy wraps through 144,233,121)
        fill(cyc_n + 1, 32'd0, 32'd1, 400);
        tick();
        wr(32'h00, 32'h1, 4'hF);
        repeat (19) tick();
        rd_chk("clean_match", 32'h08, r32, r8);
        check("clean_match18", r32, 32'd18);
        check("clean_match18_w8", r8, 32'd18);
        rd_chk("clean_err", 32'h0C, r32, r8);
        check("clean_err0_w8", r8, 32'd0);
        rd_chk("clean_status", 32'h04, r32, r8);
        check("clean_state3", r32 & 32'h3, 32'd3);

        // 99 replaces 13 in the 32-bit stream
        base = cyc_n + 1;
        fill(base, 32'd0, 32'd1, 400);
        s32[base + 7] = 32'd99;
        tick();
        wr(32'h00, 32'h3, 4'hF);
        repeat (30) tick();
        rd_chk("inj_err", 32'h0C, r32, r8);
        check("inj_err3", r32, 32'd3);
        rd_chk("inj_match",  32'h08, r32, r8);
        rd_chk("inj_fexp",   32'h10, r32, r8);
        rd_chk("inj_fobs",   32'h14, r32, r8);
`ifdef FIB_CHECK_FIRST_ERR_EN
        check("inj_fobs99", r32, 32'd99);
`else
        check("inj_fobs0", r32, 32'd0);
`endif
        rd_chk("inj_status", 32'h04, r32, r8);

        // Clear lands on a cycle whose compare would mismatch; that compare must be dropped
        s32[cyc_n + 1] = s32[cyc_n + 1] + 32'd7;
        s8[cyc_n + 1]  = (s8[cyc_n + 1] + 32'd7) & 32'hFF;
        tick();
        fill(cyc_n + 1, $urandom, $urandom, 400);
        tick();
        wr(32'h00, 32'h3, 4'hF);
        rd_chk("clr_status", 32'h04, r32, r8);
        rd_chk("clr_err", 32'h0C, r32, r8);
        check("clr_err0", r32, 32'd0);
        rd_chk("clr_match", 32'h08, r32, r8);
        repeat (12) tick();
        rd_chk("clr_match_later", 32'h08, r32, r8);

        // Random seeds with random corrupted terms
        for (int it = 0; it < 5; it++) begin
            base = cyc_n + 1;
            sa   = $urandom;
            sb   = $urandom;
            fill(base, sa, sb, 400);
            for (int k = 0; k < 1 + (it % 3); k++) begin
                int pos;
                pos = base + 2 + int'($urandom_range(0, 30));
                s32[pos] = $urandom;
                s8[pos]  = $urandom & 32'hFF;
            end
            tick();
            wr(32'h00, 32'h3, 4'hF);
            repeat (40) tick();
            rd_chk("rnd_match",  32'h08, r32, r8);
            rd_chk("rnd_err",    32'h0C, r32, r8);
            rd_chk("rnd_fexp",   32'h10, r32, r8);
            rd_chk("rnd_fobs",   32'h14, r32, r8);
            rd_chk("rnd_status", 32'h04, r32, r8);
        end

        // Disable: back to IDLE, counters and sticky error frozen
        wr(32'h00, 32'h0, 4'hF);
        rd_chk("dis_status", 32'h04, r32, r8);
        check("dis_state0", r32 & 32'h7, 32'd0);
        repeat (6) tick();
        rd_chk("dis_match", 32'h08, r32, r8);
        rd_chk("dis_ctrl",  32'h00, r32, r8);

        // Run with a fault so error is set, then reset during a pending read
        base = cyc_n + 1;
        fill(base, $urandom, $urandom, 400);
        s32[base + 5] = s32[base + 5] ^ 32'h1;
        s8[base + 5]  = s8[base + 5] ^ 32'h1;
        tick();
        wr(32'h00, 32'h3, 4'hF);
        repeat (20) tick();
        check("pre_rst_error", {31'b0, error32}, 32'd1);
        stb    = 1'b1;
        wb_cyc = 1'b1;
        we     = 1'b0;
        sel    = 4'hF;
        adr    = 32'h04;
        #2;
        reset_n = 1'b0;
        #1;
        have_run = 1'b0;
        en_on    = 1'b0;
        check("midrst_ack",    {31'b0, ack32},    32'd0);
        check("midrst_dat",    dat32,             32'd0);
        check("midrst_locked", {31'b0, locked32}, 32'd0);
        check("midrst_error",  {31'b0, error32},  32'd0);
        check("midrst_error8", {31'b0, error8},   32'd0);
        tick();
        check("midrst_noack", {31'b0, ack32}, 32'd0);
        stb    = 1'b0;
        wb_cyc = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        rd_chk("post_rst_ctrl", 32'h00, r32, r8);
        check("post_rst_ctrl0", r32, 32'd0);
        rd_chk("post_rst_err", 32'h0C, r32, r8);

        // Unmapped offset and masked byte lane
        rd_chk("unmapped_1c", 32'h1C, r32, r8);
        check("unmapped_1c0", r32, 32'd0);
        wr(32'h18, 32'hFFFF_FFFF, 4'hF);
        wr(32'h00, 32'hFF, 4'h0);
        rd_chk("sel0_ctrl", 32'h00, r32, r8);
        check("sel0_ctrl0", r32, 32'd0);
        rd_chk("sel0_status", 32'h04, r32, r8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
